// File: rtl/debnc_multi.sv
// rtl/debnc_multi.sv - multi-channel switch debouncer with shared tick prescaler
// Each channel: 2-flop synchroniser, 4-state debounce FSM, registered rise/fall pulses.
module debnc_multi #(
    parameter int N            = 4,
    parameter int TICK_DIV     = 1000000,
    parameter int STABLE_TICKS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    output logic [N-1:0] db,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_LO   = 2'b00,
        ST_W_HI = 2'b01,
        ST_HI   = 2'b10,
        ST_W_LO = 2'b11
    } state_t;

    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_sync2;
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    state_t        r_state     [N];
    state_t        w_state_nxt [N];
    logic [CW-1:0] r_cnt       [N];
    logic [CW-1:0] w_cnt_nxt   [N];
    logic [N-1:0]  r_rise;
    logic [N-1:0]  r_fall;
    logic [N-1:0]  w_rise_nxt;
    logic [N-1:0]  w_fall_nxt;
    logic [N-1:0]  w_db;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running prescaler shared by every channel
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= ST_LO;
                r_cnt[i]   <= '0;
            end
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    // A level change during a wait aborts it before any tick is considered
    always_comb begin
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_LO: begin
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = ST_W_HI;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_W_HI: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = ST_LO;
                        w_cnt_nxt[i]   = '0;
                    end else if (w_tick) begin
                        if (r_cnt[i] == CNT_LAST) begin
                            w_state_nxt[i] = ST_HI;
                            w_cnt_nxt[i]   = '0;
                            w_rise_nxt[i]  = 1'b1;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                        end
                    end
                end
                ST_HI: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = ST_W_LO;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_W_LO: begin
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = ST_HI;
                        w_cnt_nxt[i]   = '0;
                    end else if (w_tick) begin
                        if (r_cnt[i] == CNT_LAST) begin
                            w_state_nxt[i] = ST_LO;
                            w_cnt_nxt[i]   = '0;
                            w_fall_nxt[i]  = 1'b1;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_LO;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_db = '0;
        for (int i = 0; i < N; i++) begin
            w_db[i] = (r_state[i] == ST_HI) || (r_state[i] == ST_W_LO);
        end
    end

    assign db   = w_db;
    assign rise = r_rise;
    assign fall = r_fall;
    assign tick = w_tick;

endmodule

// File: tb/tb_debnc_multi.sv
// tb/tb_debnc_multi.sv - scoreboard bench for debnc_multi (N=4, TICK_DIV=10, STABLE_TICKS=3)
module tb_debnc_multi;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       tick;

    debnc_multi #(.N(4), .TICK_DIV(10), .STABLE_TICKS(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .db   (db),
        .rise (rise),
        .fall (fall),
        .tick (tick)
    );

    typedef struct {
        int ch;
        bit is_rise;
        int lo;
        int hi;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  r_cyc  = 0;
    int  c      = 0;
    int  bw[4]  = '{1, 3, 7, 15};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest expected event
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rise[i] || fall[i]) begin
                checks++;
                if (rise[i] && fall[i]) begin
                    errors++;
                    $display("FAIL pulse_both: ch%0d rise=1 fall=1 at cycle %0d, required at most one", i, cyc);
                end else if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: ch%0d rise=%b fall=%b at cycle %0d, required no pulse",
                             i, rise[i], fall[i], cyc);
                end else begin
                    e = q.pop_front();
                    if (e.ch != i || e.is_rise != rise[i] || cyc < e.lo || cyc > e.hi || db[i] != rise[i]) begin
                        errors++;
                        $display("FAIL pulse_event: got ch%0d rise=%b db=%b cycle %0d, required ch%0d rise=%b cycle %0d..%0d",
                                 i, rise[i], db[i], cyc, e.ch, e.is_rise, e.lo, e.hi);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_db(input int ch, input logic val, input int budget);
        int n = 0;
        while (db[ch] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (db[ch] !== val) begin
            errors++;
            $display("FAIL wait_db: db[%0d]=%b required %b within %0d cycles", ch, db[ch], val, budget);
        end
    endtask

    task automatic push(input int ch, input bit is_rise, input int lo, input int hi);
        ev_t ev;
        ev.ch = ch;
        ev.is_rise = is_rise;
        ev.lo = lo;
        ev.hi = hi;
        q.push_back(ev);
    endtask

    // A change driven at the negedge of cycle c lands on db between c+24 and c+33
    initial begin
        rst = 1'b0;
        sw  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        r_cyc = cyc;
        chk("reset_outputs", {24'd0, db, rise}, 32'd0);
        chk("reset_fall_tick", {27'd0, fall, tick}, 32'd0);
        rst = 1'b1;

        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("tick_period", {31'd0, tick}, {31'd0, ((cyc - r_cyc) % 10) == 9});
            chk("idle_outputs", {20'd0, db, rise, fall}, 32'd0);
        end

        sw[0] = 1'b1;
        c = cyc;
        push(0, 1'b1, c + 24, c + 33);
        wait_db(0, 1'b1, 50);
        chk("ch0_others_low", {29'd0, db[3:1]}, 32'd0);

        for (int k = 0; k < 4; k++) begin
            sw[1] = 1'b1;
            repeat (bw[k]) @(negedge clk);
            sw[1] = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("ch1_bounce_db", {31'd0, db[1]}, 32'd0);
        sw[1] = 1'b1;
        c = cyc;
        push(1, 1'b1, c + 24, c + 33);
        wait_db(1, 1'b1, 50);

        while (((cyc + 4 - r_cyc) % 10) != 0) @(negedge clk);
        sw[2] = 1'b1;
        c = cyc;
        repeat (21) @(negedge clk);
        sw[2] = 1'b0;
        repeat (40) @(negedge clk);
        chk("ch2_abort_db", {31'd0, db[2]}, 32'd0);

        sw[3] = 1'b1;
        c = cyc;
        push(3, 1'b1, c + 24, c + 33);
        wait_db(3, 1'b1, 50);
        repeat (3) @(negedge clk);
        sw[3] = 1'b0;
        c = cyc;
        push(3, 1'b0, c + 13 + 24, c + 13 + 33);
        repeat (12) @(negedge clk);
        sw[3] = 1'b1;
        @(negedge clk);
        sw[3] = 1'b0;
        repeat (15) @(negedge clk);
        chk("ch3_glitch_db", {31'd0, db[3]}, 32'd1);
        wait_db(3, 1'b0, 60);

        sw  = 4'b0000;
        rst = 1'b0;
        @(negedge clk);
        r_cyc = cyc;
        chk("reset2_outputs", {20'd0, db, rise, fall}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        while (((cyc + 4 - r_cyc) % 10) != 0) @(negedge clk);
        sw[0] = 1'b1;
        c = cyc;
        repeat (18) @(negedge clk);
        chk("ch0_waiting_db", {31'd0, db[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        r_cyc = cyc;
        chk("midwait_reset_out", {24'd0, db, rise}, 32'd0);
        rst = 1'b1;
        push(0, 1'b1, c + 19 + 24, c + 19 + 33);
        wait_db(0, 1'b1, 60);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
